// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - load/store sequencer for a direct-mapped write-back, write-allocate cache
// Misses write back a dirty victim, fetch and install the new line, then replay the access.
module cache_miss_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHE_SIZE      = 1024,
  parameter int CACHE_LINE_SIZE = 32,
  localparam int OFFSET_W = $clog2(CACHE_LINE_SIZE),
  localparam int INDEX_W  = $clog2(CACHE_SIZE / CACHE_LINE_SIZE),
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W,
  localparam int LINE_W   = CACHE_LINE_SIZE * 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_cache_re,
  output logic                  o_cache_we,
  output logic                  o_cache_fe,
  output logic                  o_cache_valid,
  output logic                  o_cache_dirty,
  output logic [OFFSET_W-1:0]   o_cache_offset,
  output logic [INDEX_W-1:0]    o_cache_index,
  output logic [TAG_W-1:0]      o_cache_tag,
  output logic [LINE_W-1:0]     o_cache_fdata,
  output logic [DATA_WIDTH-1:0] o_cache_wdata,
  input  logic                  i_cache_hit,
  input  logic                  i_cache_dirty,
  input  logic [TAG_W-1:0]      i_cache_tag,
  input  logic [LINE_W-1:0]     i_cache_vdata,
  input  logic [DATA_WIDTH-1:0] i_cache_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [LINE_W-1:0]     o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [LINE_W-1:0]     i_mem_rdata
);

  // WB_GAP keeps o_mem_req low for one cycle between the writeback ack and the fetch.
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    WRITEBACK,
    WB_GAP,
    FILL,
    INSTALL
  } state_t;

  state_t state;
  state_t next_state;

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [TAG_W-1:0]      victim_tag;
  logic [LINE_W-1:0]     victim_line;
  logic [LINE_W-1:0]     fill_line;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;

  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_index = req_addr[OFFSET_W +: INDEX_W];

  assign o_cache_offset = req_addr[OFFSET_W-1:0];
  assign o_cache_index  = req_index;
  assign o_cache_tag    = req_tag;
  assign o_cache_wdata  = req_wdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      victim_tag  <= '0;
      victim_line <= '0;
      fill_line   <= '0;
    end else begin
      if (state == IDLE && i_req_valid) begin
        req_we    <= i_req_we;
        req_addr  <= i_req_addr;
        req_wdata <= i_req_wdata;
      end
      if (state == COMPARE && !i_cache_hit) begin
        victim_tag  <= i_cache_tag;
        victim_line <= i_cache_vdata;
      end
      if (state == FILL && i_mem_ack) begin
        fill_line <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    next_state    = state;
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_rsp_rdata   = '0;
    o_cache_re    = 1'b0;
    o_cache_we    = 1'b0;
    o_cache_fe    = 1'b0;
    o_cache_valid = 1'b0;
    o_cache_dirty = 1'b0;
    o_cache_fdata = '0;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;

    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          next_state = LOOKUP;
        end
      end

      LOOKUP: begin
        o_cache_re = 1'b1;
        next_state = COMPARE;
      end

      COMPARE: begin
        // The cache only commits the store word when this lookup hits.
        if (req_we) begin
          o_cache_re = 1'b1;
          o_cache_we = 1'b1;
        end
        if (i_cache_hit) begin
          o_rsp_valid = 1'b1;
          o_rsp_rdata = req_we ? '0 : i_cache_rdata;
          next_state  = IDLE;
        end else begin
          next_state = i_cache_dirty ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {victim_tag, req_index, {OFFSET_W{1'b0}}};
        o_mem_wdata = victim_line;
        if (i_mem_ack) begin
          next_state = WB_GAP;
        end
      end

      WB_GAP: begin
        next_state = FILL;
      end

      FILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
        if (i_mem_ack) begin
          next_state = INSTALL;
        end
      end

      INSTALL: begin
        o_cache_fe    = 1'b1;
        o_cache_valid = 1'b1;
        o_cache_fdata = fill_line;
        next_state    = LOOKUP;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
